// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing generator: standard mode constant
// sets, sync polarity encodings and a constant-foldable clog2 helper.
package vga_timing_pkg;

  // Sync polarity encodings (value of the sync pin while asserted)
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int   VGA_640x480_H_ACTIVE = 640;
  localparam int   VGA_640x480_H_FP     = 16;
  localparam int   VGA_640x480_H_SYNC   = 96;
  localparam int   VGA_640x480_H_BP     = 48;
  localparam int   VGA_640x480_V_ACTIVE = 480;
  localparam int   VGA_640x480_V_FP     = 10;
  localparam int   VGA_640x480_V_SYNC   = 2;
  localparam int   VGA_640x480_V_BP     = 33;
  localparam logic VGA_640x480_HS_POL   = SYNC_ACTIVE_LOW;
  localparam logic VGA_640x480_VS_POL   = SYNC_ACTIVE_LOW;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int   VGA_800x600_H_ACTIVE = 800;
  localparam int   VGA_800x600_H_FP     = 40;
  localparam int   VGA_800x600_H_SYNC   = 128;
  localparam int   VGA_800x600_H_BP     = 88;
  localparam int   VGA_800x600_V_ACTIVE = 600;
  localparam int   VGA_800x600_V_FP     = 1;
  localparam int   VGA_800x600_V_SYNC   = 4;
  localparam int   VGA_800x600_V_BP     = 23;
  localparam logic VGA_800x600_HS_POL   = SYNC_ACTIVE_HIGH;
  localparam logic VGA_800x600_VS_POL   = SYNC_ACTIVE_HIGH;

  // Number of bits needed to hold the values 0 .. value-1
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video address/sync bundle between the timing generator (master) and the
// video RAM addressing / pixel shifter side (slave). col/row are shared
// with the CPU and are released when oe_n is high; the bus idles high.
interface vga_timing_gen_if #(
  parameter int COL_W    = 7,
  parameter int ROW_W    = 10,
  parameter int SCROLL_W = 6
);

  tri1 [COL_W-1:0]    col;
  tri1 [ROW_W-1:0]    row;
  logic               blank;
  logic               vblank_n;
  logic               hsync;
  logic               vsync;
  logic               shload_n;
  logic               oe_n;
  logic [SCROLL_W-1:0] scroll;

  modport master (
    output col, row, blank, vblank_n, hsync, vsync, shload_n,
    input  oe_n, scroll
  );

  modport slave (
    input  col, row, blank, vblank_n, hsync, vsync, shload_n,
    output oe_n, scroll
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter
// with combinational wrap, active-area and sync decodes. The owner
// registers the decodes, so these outputs are aligned with count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = SYNC_ACTIVE_LOW,
  localparam int  TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int  CW     = clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  // A zero-length region would collapse the sync decode
  if ((ACTIVE <= 0) || (FP <= 0) || (SYNC <= 0) || (BP <= 0)) begin : g_bad_timing
    $error("vga_axis_counter: active, porch and sync lengths must all be non-zero");
  end

  // Position counter, advances on inc and wraps after the last position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CW{1'b0}};
    end else if (inc) begin
      if (count == LAST) begin
        count <= {CW{1'b0}};
      end else begin
        count <= count + CW'(1);
      end
    end else begin
      count <= count;
    end
  end

  // Region decodes for the current position
  always_comb begin
    wrap   = inc && (count == LAST);
    active = (count < ACTIVE_END);
    if ((count >= SYNC_START) && (count < SYNC_END)) begin
      sync = POL;
    end else begin
      sync = ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: H/V sync, blanking, character-cell column and
// scrolled row addresses and pixel shift-register load strobes.
// Optional feature macro: VGA_SCROLL_EN (frame-synchronous vertical scroll).
// Without it the scroll input is ignored and row follows the line counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA_640x480_H_ACTIVE,
  parameter int   H_FP      = VGA_640x480_H_FP,
  parameter int   H_SYNC    = VGA_640x480_H_SYNC,
  parameter int   H_BP      = VGA_640x480_H_BP,
  parameter int   V_ACTIVE  = VGA_640x480_V_ACTIVE,
  parameter int   V_FP      = VGA_640x480_V_FP,
  parameter int   V_SYNC    = VGA_640x480_V_SYNC,
  parameter int   V_BP      = VGA_640x480_V_BP,
  parameter int   CELL_LOG2 = 3,
  parameter int   ROW_LOG2  = 3,
  parameter int   SCROLL_W  = 6,
  parameter logic HS_POL    = VGA_640x480_HS_POL,
  parameter logic VS_POL    = VGA_640x480_VS_POL
) (
  input logic              pclk,
  input logic              rst_n,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = clog2(H_TOTAL);
  localparam int VCW     = clog2(V_TOTAL);
  localparam int COL_W   = HCW - CELL_LOG2;

  // Cells must tile the visible line exactly
  if ((CELL_LOG2 < 1) || ((H_ACTIVE % (1 << CELL_LOG2)) != 0)) begin : g_bad_cell
    $error("vga_timing_gen: H_ACTIVE must be a multiple of 2**CELL_LOG2 (CELL_LOG2 >= 1)");
  end

  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic           h_wrap;
  logic           h_active;
  logic           h_sync;
  logic           v_active;
  logic           v_sync;
  logic           unused_v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk    (pclk),
    .rst_n  (rst_n),
    .inc    (1'b1),
    .count  (hcnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk    (pclk),
    .rst_n  (rst_n),
    .inc    (h_wrap),
    .count  (vcnt),
    .wrap   (unused_v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  logic [VCW-1:0] row_next;

`ifdef VGA_SCROLL_EN
  localparam int OFF_W = SCROLL_W + ROW_LOG2;
  localparam int SUM_W = ((VCW > OFF_W) ? VCW : OFF_W) + 1;
  localparam logic [VCW-1:0] LATCH_LINE = VCW'(V_ACTIVE);

  logic [VCW-1:0]   off_latched;
  logic [SUM_W-1:0] off_req;
  logic [SUM_W-1:0] row_sum;
  logic             latch_now;

  // Requested offset and the start-of-vblank latch point
  always_comb begin
    off_req   = SUM_W'(vid.scroll) << ROW_LOG2;
    latch_now = (hcnt == {HCW{1'b0}}) && (vcnt == LATCH_LINE);
  end

  // Offset only changes at start of vblank; out-of-range requests become 0
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      off_latched <= {VCW{1'b0}};
    end else if (latch_now) begin
      if (off_req >= SUM_W'(V_ACTIVE)) begin
        off_latched <= {VCW{1'b0}};
      end else begin
        off_latched <= VCW'(off_req);
      end
    end else begin
      off_latched <= off_latched;
    end
  end

  // Active lines are offset modulo V_ACTIVE; off_latched < V_ACTIVE so one subtract suffices
  always_comb begin
    row_sum = SUM_W'(vcnt) + SUM_W'(off_latched);
    if (!v_active) begin
      row_next = vcnt;
    end else if (row_sum >= SUM_W'(V_ACTIVE)) begin
      row_next = VCW'(row_sum - SUM_W'(V_ACTIVE));
    end else begin
      row_next = VCW'(row_sum);
    end
  end
`else
  logic unused_scroll;
  assign unused_scroll = ^vid.scroll;

  // Without scrolling the row address is the raw line counter
  always_comb begin
    row_next = vcnt;
  end
`endif

  logic [COL_W-1:0] col_r;
  logic [VCW-1:0]   row_r;
  logic             blank_r;
  logic             vblank_n_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             shload_n_r;
  logic             cell_last;

  assign cell_last = &hcnt[CELL_LOG2-1:0];

  // Output registers: every output lags the counters by one pclk
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      col_r      <= {COL_W{1'b0}};
      row_r      <= {VCW{1'b0}};
      blank_r    <= 1'b1;
      vblank_n_r <= 1'b1;
      hsync_r    <= ~HS_POL;
      vsync_r    <= ~VS_POL;
      shload_n_r <= 1'b1;
    end else begin
      col_r      <= hcnt[HCW-1:CELL_LOG2];
      row_r      <= row_next;
      blank_r    <= ~(h_active && v_active);
      vblank_n_r <= v_active;
      hsync_r    <= h_sync;
      vsync_r    <= v_sync;
      shload_n_r <= ~(h_active && v_active && cell_last);
    end
  end

  // Address bus is released to the CPU while oe_n is high
  assign vid.col      = vid.oe_n ? {COL_W{1'bz}} : col_r;
  assign vid.row      = vid.oe_n ? {VCW{1'bz}}   : row_r;
  assign vid.blank    = blank_r;
  assign vid.vblank_n = vblank_n_r;
  assign vid.hsync    = hsync_r;
  assign vid.vsync    = vsync_r;
  assign vid.shload_n = shload_n_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced video mode so whole
// frames fit in a short run. Expected outputs come from a position-based
// arithmetic model (pixel index -> h, v) plus hand-derived spot tables.
module tb_vga_timing_gen;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int CL = 3, RL = 2, SW = 4;
  localparam int HT = HA + HF + HS + HB;   // 48
  localparam int VT = VA + VF + VS + VB;   // 31
  localparam int COL_W = 3;                // clog2(48) - 3
  localparam int ROW_W = 5;                // clog2(31)
`ifdef VGA_SCROLL_EN
  localparam bit SCROLL_ON = 1'b1;
`else
  localparam bit SCROLL_ON = 1'b0;
`endif

  logic pclk  = 1'b0;
  logic rst_n = 1'b1;

  vga_timing_gen_if #(.COL_W(COL_W), .ROW_W(ROW_W), .SCROLL_W(SW)) vif ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CELL_LOG2(CL), .ROW_LOG2(RL), .SCROLL_W(SW),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .vid   (vif)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic blank, vblank_n, hsync, vsync, shload_n;
  } vout_t;

  typedef struct {
    int h, v, col, row;
    logic blank, vblank_n, hsync, vsync, shload_n;
  } spot_t;

  int    checks, errors;
  int    pidx, lat_off, cap_h, cap_v;
  vout_t expv;
  spot_t spots[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expd);
    checks++;
    if (act !== expd) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", nm, act, expd, cap_h, cap_v);
    end
  endtask

  // Expected outputs for screen position (h, v) with a given scroll offset
  function automatic vout_t model(int h, int v, int off, logic oe);
    vout_t o;
    bit act;
    int r;
    act = (h < HA) && (v < VA);
    r   = v;
    if (v < VA) begin
      r = v + off;
      if (r >= VA) r = r - VA;
    end
    o.col      = oe ? {COL_W{1'b1}} : COL_W'(h / (1 << CL));
    o.row      = oe ? {ROW_W{1'b1}} : ROW_W'(r);
    o.blank    = !act;
    o.vblank_n = (v < VA);
    o.hsync    = !((h >= HA + HF) && (h < HA + HF + HS));
    o.vsync    = !((v >= VA + VF) && (v < VA + VF + VS));
    o.shload_n = !(act && ((h % (1 << CL)) == (1 << CL) - 1));
    return o;
  endfunction

  task automatic cmp_all();
    chk("col", vif.col, expv.col);
    chk("row", vif.row, expv.row);
    chk("blank", vif.blank, expv.blank);
    chk("vblank_n", vif.vblank_n, expv.vblank_n);
    chk("hsync", vif.hsync, expv.hsync);
    chk("vsync", vif.vsync, expv.vsync);
    chk("shload_n", vif.shload_n, expv.shload_n);
  endtask

  // One pclk: advance the model position, then compare on the falling edge
  task automatic cyc();
    int off_used;
    int req;
    @(posedge pclk);
    cap_h    = pidx % HT;
    cap_v    = (pidx / HT) % VT;
    off_used = lat_off;
    if (SCROLL_ON && cap_h == 0 && cap_v == VA) begin
      req     = int'(vif.scroll) << RL;
      lat_off = (req >= VA) ? 0 : req;
    end
    pidx++;
    @(negedge pclk);
    expv = model(cap_h, cap_v, off_used, vif.oe_n);
    cmp_all();
  endtask

  // Run (checking every cycle) until the outputs show position (h, v)
  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(cap_h == h && cap_v == v) && n < 2 * HT * VT);
    checks++;
    if (!(cap_h == h && cap_v == v)) begin
      errors++;
      $display("FAIL run_to: got h=%0d v=%0d expected h=%0d v=%0d", cap_h, cap_v, h, v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_col"}, vif.col, 0);
    chk({tag, "_row"}, vif.row, 0);
    chk({tag, "_blank"}, vif.blank, 1);
    chk({tag, "_vblank_n"}, vif.vblank_n, 1);
    chk({tag, "_hsync"}, vif.hsync, 1);
    chk({tag, "_vsync"}, vif.vsync, 1);
    chk({tag, "_shload_n"}, vif.shload_n, 1);
  endtask

  initial begin
    int n_hs, n_vs, n_vb, n_sl, n_hfall;
    logic prev_hs;
    checks = 0; errors = 0; pidx = 0; lat_off = 0; cap_h = 0; cap_v = 0;
    vif.oe_n   = 1'b0;
    vif.scroll = '0;

    //             h   v  col row blank vbn hs vs shl
    spots[0]  = '{ 0,  0, 0,  0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    spots[1]  = '{ 7,  0, 0,  0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    spots[2]  = '{31,  0, 3,  0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    spots[3]  = '{32,  0, 4,  0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    spots[4]  = '{35,  0, 4,  0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    spots[5]  = '{36,  0, 4,  0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    spots[6]  = '{41,  0, 5,  0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    spots[7]  = '{42,  0, 5,  0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    spots[8]  = '{47,  0, 5,  0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    spots[9]  = '{ 7,  1, 0,  1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    spots[10] = '{ 0, 23, 0, 23,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    spots[11] = '{ 0, 24, 0, 24,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    spots[12] = '{ 0, 26, 0, 26,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    spots[13] = '{47, 27, 5, 27,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    spots[14] = '{ 0, 28, 0, 28,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    spots[15] = '{15, 30, 1, 30,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Power-on reset, released at t=10 (a falling clock edge)
    #1 rst_n = 1'b0;
    #1 chk_reset("rst_t2");
    #8 rst_n = 1'b1;
    #2 chk_reset("rst_t12");

    // Spot table over the first frame (scroll 0)
    for (int i = 0; i < 16; i++) begin
      run_to(spots[i].h, spots[i].v);
      chk("spot_col", vif.col, spots[i].col);
      chk("spot_row", vif.row, spots[i].row);
      chk("spot_blank", vif.blank, spots[i].blank);
      chk("spot_vblank_n", vif.vblank_n, spots[i].vblank_n);
      chk("spot_hsync", vif.hsync, spots[i].hsync);
      chk("spot_vsync", vif.vsync, spots[i].vsync);
      chk("spot_shload_n", vif.shload_n, spots[i].shload_n);
    end

    // One full frame period: pulse widths and counts
    n_hs = 0; n_vs = 0; n_vb = 0; n_sl = 0; n_hfall = 0;
    prev_hs = vif.hsync;
    for (int i = 0; i < HT * VT; i++) begin
      cyc();
      if (!vif.hsync) n_hs++;
      if (!vif.vsync) n_vs++;
      if (!vif.vblank_n) n_vb++;
      if (!vif.shload_n) n_sl++;
      if (prev_hs && !vif.hsync) n_hfall++;
      prev_hs = vif.hsync;
    end
    chk("frame_hsync_low", n_hs, HS * VT);
    chk("frame_hsync_pulses", n_hfall, VT);
    chk("frame_vsync_low", n_vs, VS * HT);
    chk("frame_vblank_low", n_vb, (VT - VA) * HT);
    chk("frame_shload_pulses", n_sl, (HA >> CL) * VA);

    // Scroll by 5 units (20 lines) from the next frame
    vif.scroll = 4'd5;
    run_to(0, 24);
    run_to(0, 0);
    chk("scroll5_line0_row", vif.row, SCROLL_ON ? 20 : 0);
    run_to(0, 4);
    chk("scroll5_line4_row", vif.row, SCROLL_ON ? 0 : 4);
    run_to(0, 10);
    vif.scroll = 4'd2;
    run_to(0, 12);
    chk("scroll_midframe_row", vif.row, SCROLL_ON ? 8 : 12);
    run_to(0, 23);
    chk("scroll_last_line_row", vif.row, SCROLL_ON ? 19 : 23);
    run_to(0, 0);
    chk("scroll2_line0_row", vif.row, SCROLL_ON ? 8 : 0);

    // Offset of exactly V_ACTIVE is ignored
    vif.scroll = 4'd6;
    run_to(0, 24);
    run_to(0, 5);
    chk("scroll_ignored_row", vif.row, 5);

    // Release the address bus mid-line
    run_to(10, 3);
    vif.oe_n = 1'b1;
    #1;
    chk("oe_release_col", vif.col, 7);
    chk("oe_release_row", vif.row, 31);
    run_to(0, 4);
    chk("oe_hsync_line", vif.hsync, 1);
    vif.oe_n = 1'b0;
    #1;
    chk("oe_return_col", vif.col, 0);
    chk("oe_return_row", vif.row, 4);

    // Random scroll / bus-release traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ($urandom_range(0, 99) < 3) vif.scroll = SW'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 2) vif.oe_n = 1'($urandom_range(0, 1));
    end
    vif.oe_n = 1'b0;

    // Reset mid-line: immediate return to reset values, restart at (0,0)
    run_to(20, 5);
    rst_n = 1'b0;
    #1 chk_reset("midrst_async");
    @(posedge pclk);
    #1 chk_reset("midrst_hold");
    @(negedge pclk);
    rst_n   = 1'b1;
    pidx    = 0;
    lat_off = 0;
    cyc();
    chk("midrst_first_h", cap_h, 0);
    chk("midrst_first_col", vif.col, 0);
    chk("midrst_first_blank", vif.blank, 0);
    run_to(0, 1);
    chk("midrst_line1_row", vif.row, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
